idle_generator: RTL and testbench



---
 rtl/idle_generator.sv | 96 +++++++++
 tb/tb_idle_generator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/idle_generator.sv
// Aurora 8B/10B idle-sequence generator for one TX lane: /A/ at LFSR-driven spacing, /K/ and /R/ fill.
// Build option IDLE_GEN_RANDOM_KR_EN selects LFSR-chosen K/R fill; default is strict K,R alternation.
module idle_generator #(
  parameter logic [6:0] LFSR_SEED = 7'h5A,
  parameter int         A_MIN     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic send_idle,
  output logic send_K,
  output logic send_A,
  output logic send_R
);

  // A zero seed would lock the LFSR, so it is replaced at elaboration time.
  localparam logic [6:0] SEED_EFF      = (LFSR_SEED == 7'h00) ? 7'h01 : LFSR_SEED;
  localparam logic [4:0] A_RELOAD_BASE = 5'(A_MIN - 1);

  logic [6:0] lfsr_q, lfsr_d;
  logic [4:0] a_cnt_q, a_cnt_d;
  logic       send_k_q, send_k_d;
  logic       send_a_q, send_a_d;
  logic       send_r_q, send_r_d;
  logic       fill_k;

`ifndef IDLE_GEN_RANDOM_KR_EN
  logic       tog_q, tog_d;
`endif

`ifdef IDLE_GEN_RANDOM_KR_EN
  assign fill_k = lfsr_q[0];
`else
  assign fill_k = ~tog_q;
`endif

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    lfsr_d   = lfsr_q;
    a_cnt_d  = a_cnt_q;
    send_k_d = 1'b0;
    send_a_d = 1'b0;
    send_r_d = 1'b0;
`ifndef IDLE_GEN_RANDOM_KR_EN
    tog_d    = tog_q;
`endif

    if (lfsr_q == 7'h00) begin
      lfsr_d = 7'h01;
    end else if (send_idle) begin
      lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end

    if (send_idle) begin
      if (a_cnt_q == 5'd0) begin
        send_a_d = 1'b1;
        a_cnt_d  = A_RELOAD_BASE + {1'b0, lfsr_q[3:0]};
      end else begin
        a_cnt_d  = a_cnt_q - 5'd1;
        send_k_d = fill_k;
        send_r_d = ~fill_k;
`ifndef IDLE_GEN_RANDOM_KR_EN
        tog_d    = ~tog_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= SEED_EFF;
      a_cnt_q  <= 5'd0;
      send_k_q <= 1'b0;
      send_a_q <= 1'b0;
      send_r_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      lfsr_q   <= lfsr_d;
      a_cnt_q  <= a_cnt_d;
      send_k_q <= send_k_d;
      send_a_q <= send_a_d;
      send_r_q <= send_r_d;
    end
  end

`ifndef IDLE_GEN_RANDOM_KR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tog_q <= 1'b0;
    else        tog_q <= tog_d;
  end
`endif

  assign send_K = send_k_q;
  assign send_A = send_a_q;
  assign send_R = send_r_q;

endmodule

// File: tb/tb_idle_generator.sv
// Self-checking bench for idle_generator: behavioural model, per-cycle compare, stream statistics,
// pause/resume and asynchronous mid-stream reset with bit-exact restart.
`timescale 1ns/1ps
module tb_idle_generator;

  localparam logic [6:0] SEED = 7'h5A;

  logic clk, rst_n, send_idle;
  logic send_K, send_A, send_R;

  idle_generator #(.LFSR_SEED(SEED), .A_MIN(16)) dut (
    .clk(clk), .rst_n(rst_n), .send_idle(send_idle),
    .send_K(send_K), .send_A(send_A), .send_R(send_R)
  );

  initial clk = 1'b0;
  always #2.5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: distance-to-next-/A/ countdown in active cycles, seeded from the LFSR sequence.
  int       m_left;
  int       m_lfsr;
  bit       m_tog;
  bit [2:0] m_exp;   // {K, A, R}

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= (SEED == 0) ? 1 : int'(SEED);
      m_left <= 0;
      m_tog  <= 1'b0;
      m_exp  <= 3'b000;
    end else if (send_idle) begin
      int  nl;
      bit  k;
      nl = (m_lfsr == 0) ? 1 : (((m_lfsr * 2) % 128) + (((m_lfsr / 64) + (m_lfsr / 32)) % 2));
      m_lfsr <= nl;
      if (m_left == 0) begin
        m_exp  <= 3'b010;
        m_left <= 15 + (m_lfsr % 16);
      end else begin
`ifdef IDLE_GEN_RANDOM_KR_EN
        k = (m_lfsr % 2) == 1;
`else
        k = !m_tog;
        m_tog <= !m_tog;
`endif
        m_exp  <= k ? 3'b100 : 3'b001;
        m_left <= m_left - 1;
      end
    end else begin
      m_exp <= 3'b000;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_cmp", int'({send_K, send_A, send_R}), int'(m_exp));
      check("one_hot", int'((32'(send_K) + 32'(send_A) + 32'(send_R)) <= 1), 1);
    end
  end

  // Stream statistics gathered from the DUT outputs.
  int       n_sym, last_a, n_a, n_k, n_r;
  int       first_gap;
  bit [2:0] last_fill;
  int       run1 [64];

  function automatic int sym_code();
    return int'({send_K, send_A, send_R});
  endfunction

  task automatic reset_stats();
    n_sym = 0; last_a = -1; n_a = 0; n_k = 0; n_r = 0; first_gap = -1;
    last_fill = 3'b000;
  endtask

  task automatic observe();
    int c;
    c = sym_code();
    if (c == 0) return;
    if (send_A) begin
      if (last_a >= 0) begin
        check("a_gap_16_31", int'((n_sym - last_a) >= 16 && (n_sym - last_a) <= 31), 1);
        if (first_gap < 0) first_gap = n_sym - last_a;
      end
      last_a = n_sym;
      n_a++;
    end else begin
      if (send_K) n_k++;
      if (send_R) n_r++;
`ifndef IDLE_GEN_RANDOM_KR_EN
      if (last_fill == 3'b000) check("first_fill_is_K", c, 3'b100);
      else check("fill_alternates", int'(c != int'(last_fill)), 1);
      last_fill = 3'(c);
`endif
    end
    n_sym++;
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
  endtask

  int mism;
  int held;

  initial begin
    rst_n = 1'b1; send_idle = 1'b0;
    #1 rst_n = 1'b0;
    reset_stats();
    #19 rst_n = 1'b1;      // t = 20
    chk_en = 1'b1;
    check("reset_outputs", sym_code(), 0);
    @(negedge clk);        // t = 25
    @(negedge clk);        // t = 30
    send_idle = 1'b1;

    // Main run: 400 cycles of continuous idle.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 0) check("first_symbol_A", sym_code(), 3'b010);
      if (i == 1) check("second_symbol_K", sym_code(), 3'b100);
      if (i < 64) run1[i] = sym_code();
      observe();
    end
    check("first_a_gap_literal", first_gap, 26);
    check("a_count_13_26", int'(n_a >= 13 && n_a <= 26), 1);
    check("k_count_nonzero", int'(n_k > 0), 1);
    check("r_count_nonzero", int'(n_r > 0), 1);

    // Pause mid-gap for 10 cycles; the model holds its countdown too.
    while (send_A) cycle();
    for (int i = 0; i < 3; i++) cycle();
    send_idle = 1'b0;
    held = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sym_code() != 0) held++;
    end
    check("drop_quiet", held, 0);
    send_idle = 1'b1;
    for (int i = 0; i < 100; i++) cycle();

    // Asynchronous reset mid-stream, then bit-exact restart.
    check("active_before_reset", int'(sym_code() != 0), 1);
    #1 rst_n = 1'b0;
    #1 check("async_clear", sym_code(), 0);
    send_idle = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst_n = 1'b1;
    reset_stats();
    @(negedge clk);
    @(negedge clk);
    send_idle = 1'b1;
    mism = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sym_code() != run1[i]) mism++;
      observe();
    end
    check("restart_matches_first_run", mism, 0);
    check("restart_first_gap", first_gap, 26);

    send_idle = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
